full_adder_4bit: RTL and testbench
==================================

Name: full_adder_4bit

Overview:
Registered ripple-carry adder. Adds two WIDTH-bit unsigned operands plus a carry-in and produces a WIDTH-bit sum, a carry-out and a signed-overflow flag. The carry chain is built from per-bit full-adder cells, and the result is captured in output registers. It serves as the basic arithmetic slice in datapaths; default WIDTH 4 matches the 4-bit operand use.

Parameters:
WIDTH, 4, operand and sum width in bits (legal range 1..64)

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands a, b, c_in are valid this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
c_in  input  1  carry-in, weight 1
sum  output  WIDTH  registered result bits [WIDTH-1:0] of a+b+c_in
c_out  output  1  registered carry-out, bit WIDTH of a+b+c_in
overflow  output  1  registered two's-complement overflow of the same addition
out_valid  output  1  registered in_valid, one cycle delayed

Behaviour:
- Combinational core:
  - Ripple chain of WIDTH full-adder cells.
  - Cell i: s_i = a_i ^ b_i ^ k_i; k_(i+1) = a_i&b_i | a_i&k_i | b_i&k_i.
  - Chain input k_0 = c_in.
- Results:
  - Full-width result {c_out, sum} = a + b + c_in, exact (WIDTH+1 bits, range 0..2^(WIDTH+1)-1). No saturation; sum wraps modulo 2^WIDTH.
  - overflow = k_WIDTH ^ k_(WIDTH-1), i.e. a and b share a sign bit that differs from sum's MSB.
  - For WIDTH=1, overflow = c_out ^ c_in.
- Latency:
  - Exactly 1 cycle. Inputs sampled at rising edge N appear on sum/c_out/overflow/out_valid after edge N.
  - Throughput: one addition per cycle, no stalls, no back-pressure.
- Valid handling:
  - Output registers load only when in_valid=1; otherwise sum/c_out/overflow hold their last value.
  - out_valid <= in_valid every cycle.
- Reset (synchronous, active-high, sampled at rising clk):
  - sum=0, c_out=0, overflow=0, out_valid=0.
  - Reset has priority over in_valid in the same cycle; that cycle's operands are discarded.
  - Deasserting reset needs no warm-up. The first in_valid after reset produces a result the following cycle.
- Boundary cases:
  - All-ones a, b with c_in=1 -> sum all-ones, c_out=1.
  - All-zero operands with c_in=1 -> sum=1, c_out=0.
- No X propagation requirements beyond reset. Outputs are fully defined after the first reset cycle.
- No internal state besides the output registers.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, a=15, b=15, c_in=1 -> sum=0, c_out=0, overflow=0, out_valid=0.
- No carry: a=2, b=4, c_in=0 -> sum=6, c_out=0, overflow=0. Same with c_in=1 -> sum=7, c_out=0. Both checked one cycle after in_valid.
- Carry ripple through all bits: a=3, b=12, c_in=0 -> sum=15, c_out=0. With c_in=1 -> sum=0, c_out=1, overflow=0.
- Carry-out and signed overflow:
  - a=11, b=8, c_in=0 -> sum=3, c_out=1, overflow=1.
  - c_in=1 -> sum=4, c_out=1, overflow=1.
  - a=11, b=14, c_in=1 -> sum=10, c_out=1, overflow=0.
- Hold and pipelining:
  - Back-to-back valid operands (2+4+0, then 3+12+1) -> results 6/0 then 0/1 on consecutive cycles.
  - Then in_valid=0 with new a/b -> outputs hold 0/1, out_valid=0.
- Random sweep: 1000 random a, b, c_in with random in_valid. Compare {c_out,sum} against a+b+c_in and overflow against the sign rule, at 1-cycle latency; also check with WIDTH=1 and WIDTH=16.

Source files
------------

// File: rtl/full_adder_4bit.sv
// ---------------------------------------------------------------------------
// full_adder_4bit
//   Registered ripple-carry adder slice. It adds two WIDTH-bit unsigned
//   operands and a carry-in through a chain of per-bit full-adder cells. The
//   sum, carry-out and two's-complement overflow are captured in output
//   registers. Latency is one cycle, with one addition accepted per cycle.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  a/b/c_in are valid this cycle
//   a, b      WIDTH-bit operands
//   c_in      carry-in (weight 1)
//   sum       registered a+b+c_in modulo 2^WIDTH
//   c_out     registered carry out of bit WIDTH-1
//   overflow  registered signed overflow of the same addition
//   out_valid registered in_valid, one cycle delayed
// ---------------------------------------------------------------------------

// Single full-adder cell: one link of the carry chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic k,
  output logic s,
  output logic k_next
);
  assign s      = a ^ b ^ k;
  assign k_next = (a & b) | (a & k) | (b & k);
endmodule

module full_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             out_valid
);

  // k[i] is the carry into bit i. k[0] is the external carry-in.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s;

  assign k[0] = c_in;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    fa_cell u_cell (
      .a      (a[g]),
      .b      (b[g]),
      .k      (k[g]),
      .s      (s[g]),
      .k_next (k[g+1])
    );
  end

  // Signed overflow occurs when the carry into the MSB differs from the carry
  // out of it. For WIDTH=1 the carry into the MSB is c_in itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Results hold through idle cycles, so a consumer can sample late.
      if (in_valid) begin
        sum      <= s;
        c_out    <= k[WIDTH];
        overflow <= k[WIDTH] ^ k[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_full_adder_4bit.sv
// Bench for full_adder_4bit. Three instances (WIDTH 4, 1 and 16) share the
// control inputs. The operands of each instance are the low bits of one
// 16-bit value. A reference model uses plain arithmetic to predict outputs.
module tb_full_adder_4bit;
  logic        clk = 1'b0;
  logic        rst, in_valid, c_in;
  logic [15:0] a, b;

  logic [3:0]  s4;  logic c4, o4, v4;
  logic [0:0]  s1;  logic c1, o1, v1;
  logic [15:0] s16; logic c16, o16, v16;

  int tests = 0;
  int fails = 0;

  // Expected register contents per instance: index 0 = W4, 1 = W1, 2 = W16.
  int      wid [3] = '{4, 1, 16};
  longint  e_sum [3];
  logic    e_cout[3], e_ov[3], e_vld;

  always #5 clk = ~clk;

  full_adder_4bit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]),
    .c_in(c_in), .sum(s4), .c_out(c4), .overflow(o4), .out_valid(v4));
  full_adder_4bit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
    .c_in(c_in), .sum(s1), .c_out(c1), .overflow(o1), .out_valid(v1));
  full_adder_4bit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .c_in(c_in), .sum(s16), .c_out(c16), .overflow(o16), .out_valid(v16));

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model of the arithmetic: exact sum plus the sign rule for overflow.
  task automatic model(input int w, input longint x, input longint y,
                       input logic ci, output longint so, output logic co,
                       output logic ov);
    longint mask, full, xa, ya;
    logic sa, sb, ss;
    mask = (longint'(1) << w) - 1;
    xa = x & mask;
    ya = y & mask;
    full = xa + ya + longint'(ci);
    so = full & mask;
    co = ((full >> w) & 1) != 0;
    sa = ((xa >> (w - 1)) & 1) != 0;
    sb = ((ya >> (w - 1)) & 1) != 0;
    ss = ((so >> (w - 1)) & 1) != 0;
    ov = (sa == sb) && (ss != sa);
  endtask

  // Drive one cycle, advance the model, and compare every instance.
  task automatic cycle(input string tag, input logic r, input logic v,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic ci);
    longint so; logic co, ov;
    rst = r; in_valid = v; a = x; b = y; c_in = ci;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        e_sum[i] = 0; e_cout[i] = 1'b0; e_ov[i] = 1'b0;
      end else if (v) begin
        model(wid[i], longint'(x), longint'(y), ci, so, co, ov);
        e_sum[i] = so; e_cout[i] = co; e_ov[i] = ov;
      end
    end
    e_vld = !r && v;
    chk({tag, ".w4.sum"},  longint'(s4),  e_sum[0]);
    chk({tag, ".w4.cout"}, longint'(c4),  longint'(e_cout[0]));
    chk({tag, ".w4.ov"},   longint'(o4),  longint'(e_ov[0]));
    chk({tag, ".w4.vld"},  longint'(v4),  longint'(e_vld));
    chk({tag, ".w1.sum"},  longint'(s1),  e_sum[1]);
    chk({tag, ".w1.cout"}, longint'(c1),  longint'(e_cout[1]));
    chk({tag, ".w1.ov"},   longint'(o1),  longint'(e_ov[1]));
    chk({tag, ".w1.vld"},  longint'(v1),  longint'(e_vld));
    chk({tag, ".w16.sum"}, longint'(s16), e_sum[2]);
    chk({tag, ".w16.cout"},longint'(c16), longint'(e_cout[2]));
    chk({tag, ".w16.ov"},  longint'(o16), longint'(e_ov[2]));
    chk({tag, ".w16.vld"}, longint'(v16), longint'(e_vld));
  endtask

  // Directed step on the 4-bit instance with hand-derived expected values.
  task automatic dstep(input string tag, input logic v, input logic [15:0] x,
                       input logic [15:0] y, input logic ci,
                       input int es, input int ec, input int eo, input int ev);
    cycle(tag, 1'b0, v, x, y, ci);
    chk({tag, ".const.sum"},  longint'(s4), longint'(es));
    chk({tag, ".const.cout"}, longint'(c4), longint'(ec));
    chk({tag, ".const.ov"},   longint'(o4), longint'(eo));
    chk({tag, ".const.vld"},  longint'(v4), longint'(ev));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 16'd15; b = 16'd15; c_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e_sum[i] = 0; e_cout[i] = 1'b0; e_ov[i] = 1'b0;
    end
    e_vld = 1'b0;

    // Reset has priority over valid operands.
    cycle("rst0", 1'b1, 1'b1, 16'd15, 16'd15, 1'b1);
    cycle("rst1", 1'b1, 1'b1, 16'd15, 16'd15, 1'b1);
    chk("rst.const.sum", longint'(s4), 0);
    chk("rst.const.vld", longint'(v4), 0);

    dstep("nocarry0",  1'b1, 16'd2,  16'd4,  1'b0, 6,  0, 0, 1);
    dstep("nocarry1",  1'b1, 16'd2,  16'd4,  1'b1, 7,  0, 0, 1);
    dstep("ripple0",   1'b1, 16'd3,  16'd12, 1'b0, 15, 0, 0, 1);
    dstep("ripple1",   1'b1, 16'd3,  16'd12, 1'b1, 0,  1, 0, 1);
    dstep("ovf0",      1'b1, 16'd11, 16'd8,  1'b0, 3,  1, 1, 1);
    dstep("ovf1",      1'b1, 16'd11, 16'd8,  1'b1, 4,  1, 1, 1);
    dstep("ovf2",      1'b1, 16'd11, 16'd14, 1'b1, 10, 1, 0, 1);
    dstep("allones",   1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 15, 1, 0, 1);
    dstep("zeros_ci",  1'b1, 16'd0,  16'd0,  1'b1, 1,  0, 0, 1);
    // Back-to-back operands, then idle with new operands: outputs hold.
    dstep("b2b0",      1'b1, 16'd2,  16'd4,  1'b0, 6,  0, 0, 1);
    dstep("b2b1",      1'b1, 16'd3,  16'd12, 1'b1, 0,  1, 0, 1);
    dstep("hold",      1'b0, 16'd9,  16'd5,  1'b0, 0,  1, 0, 0);

    // Reset in the middle of traffic, then an immediate valid operand.
    cycle("midrst", 1'b1, 1'b1, 16'd7, 16'd7, 1'b1);
    dstep("postrst",   1'b1, 16'd5,  16'd6,  1'b0, 11, 0, 1, 1);

    for (int n = 0; n < 1000; n++) begin
      cycle("rand", 1'b0, ($urandom_range(0, 3) != 0),
            16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
